ewrapper_tx_arbiter: RTL and testbench

Core-clock transmit scheduler for the eLink TX path. It round-robins three 104-bit transaction requesters: write, read-request and read-response. Each granted packet is framed into two consecutive 72-bit words on DATA_OUT_FROM_DEVICE, which feeds the fast-clock TX serializer. Pin 8 carries the frame byte and pins 7:0 carry data lanes.

---
 rtl/ewrapper_tx_arbiter.sv | 104 ++++++++++
 tb/tb_ewrapper_tx_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ewrapper_tx_arbiter.sv
// Round-robin TX scheduler: frames each granted 104-bit packet as two 72-bit words (7F then FF frame byte).
// Word0 appears one edge after accept; TX_WAIT/elink_disable hold off new grants but never split a packet.
module ewrapper_tx_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = 104
) (
  input  logic              CLK_DIV_IN,
  input  logic              IO_RESET_N,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [NREQ*PW-1:0] REQ_PACKET,
  output logic [NREQ-1:0]   REQ_READY,
  input  logic              TX_WAIT,
  input  logic              elink_disable,
  output logic [71:0]       DATA_OUT_FROM_DEVICE,
  output logic              TX_BUSY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_W0   = 2'd1;
  localparam logic [1:0] ST_W1   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [1:0]      last_grant_q, last_grant_d;
  // Only the tail of the {packet, 24'h0} frame needs holding; the head goes out directly on accept.
  logic [63:0]     hold_q, hold_d;
  logic [71:0]     data_q, data_d;
  logic            busy_q, busy_d;

  logic [1:0]      rr0, rr1, rr2, winner;
  logic            any_vld, accept_ok, accept;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   pkt_sel;

  always_comb begin
    rr0 = (last_grant_q == 2'd2) ? 2'd0 : last_grant_q + 2'd1;
    rr1 = (rr0 == 2'd2) ? 2'd0 : rr0 + 2'd1;
    rr2 = (rr1 == 2'd2) ? 2'd0 : rr1 + 2'd1;
    any_vld = |REQ_VALID;
    if (REQ_VALID[rr0])      winner = rr0;
    else if (REQ_VALID[rr1]) winner = rr1;
    else                     winner = rr2;
    grant = any_vld ? (3'b001 << winner) : 3'b000;
  end

  assign accept_ok = (state_q != ST_W0) & ~TX_WAIT & ~elink_disable & IO_RESET_N;
  assign REQ_READY = grant & {NREQ{accept_ok}};
  assign accept    = |REQ_READY;

  always_comb begin
    case (winner)
      2'd1:    pkt_sel = REQ_PACKET[2*PW-1:PW];
      2'd2:    pkt_sel = REQ_PACKET[3*PW-1:2*PW];
      default: pkt_sel = REQ_PACKET[PW-1:0];
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    hold_d       = hold_q;
    data_d       = data_q;
    busy_d       = busy_q;
    case (state_q)
      ST_W0: begin
        state_d = ST_W1;
        data_d  = {8'hFF, hold_q};
        busy_d  = 1'b1;
      end
      default: begin
        if (accept) begin
          state_d      = ST_W0;
          last_grant_d = winner;
          hold_d       = {pkt_sel[39:0], 24'h0};
          data_d       = {8'h7F, pkt_sel[103:40]};
          busy_d       = 1'b1;
        end else begin
          state_d = ST_IDLE;
          data_d  = 72'h0;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK_DIV_IN or negedge IO_RESET_N) begin
    if (!IO_RESET_N) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 2'd2;
      hold_q       <= 64'h0;
      data_q       <= 72'h0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      hold_q       <= hold_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
    end
  end

  assign DATA_OUT_FROM_DEVICE = data_q;
  assign TX_BUSY              = busy_q;

endmodule

// File: tb/tb_ewrapper_tx_arbiter.sv
// Directed bench for ewrapper_tx_arbiter: reset, single packet, fairness, TX_WAIT, disable, reset mid-packet.
module tb_ewrapper_tx_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req_vld;
  logic [311:0] req_pkt;
  logic [2:0]   req_rdy;
  logic         tx_wait;
  logic         link_dis;
  logic [71:0]  dout;
  logic         busy;

  logic [103:0] pk [3];
  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign req_pkt = {pk[2], pk[1], pk[0]};

  ewrapper_tx_arbiter dut (
    .CLK_DIV_IN           (clk),
    .IO_RESET_N           (rst_n),
    .REQ_VALID            (req_vld),
    .REQ_PACKET           (req_pkt),
    .REQ_READY            (req_rdy),
    .TX_WAIT              (tx_wait),
    .elink_disable        (link_dis),
    .DATA_OUT_FROM_DEVICE (dout),
    .TX_BUSY              (busy)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] w0(input logic [103:0] p);
    return {8'h7F, p[103:40]};
  endfunction

  function automatic logic [71:0] w1(input logic [103:0] p);
    return {8'hFF, p[39:0], 24'h0};
  endfunction

  initial begin
    pk[0] = {4'h0, 32'h8080_0000, 2'd2, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678};
    pk[1] = {4'h3, 32'h0000_1000, 2'd1, 1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_0001};
    pk[2] = {4'hA, 32'hA5A5_5A5A, 2'd3, 1'b1, 1'b0, 32'h0F0F_F0F0, 32'h8765_4321};
    rst_n    = 1'b0;
    req_vld  = 3'b111;
    tx_wait  = 1'b0;
    link_dis = 1'b0;

    // Reset state
    #1;
    chk("rst_rdy", req_rdy, 3'b000);
    chk("rst_dout", dout, 72'h0);
    chk("rst_busy", busy, 1'b0);
    tick();
    tick();
    chk("rst_dout_clk", dout, 72'h0);
    chk("rst_rdy_clk", req_rdy, 3'b000);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", req_rdy, 3'b001);

    // Single write packet
    req_vld = 3'b001;
    #1;
    chk("s_rdy", req_rdy, 3'b001);
    tick();
    chk("s_w0", dout, w0(pk[0]));
    chk("s_busy0", busy, 1'b1);
    chk("s_rdy_w0", req_rdy, 3'b000);
    req_vld = 3'b000;
    tick();
    chk("s_w1", dout, w1(pk[0]));
    chk("s_busy1", busy, 1'b1);
    tick();
    chk("s_idle", dout, 72'h0);
    chk("s_busy_idle", busy, 1'b0);

    // Fairness: fresh reset so requester 0 leads
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req_vld = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_rdy", req_rdy, 3'b001 << (k % 3));
      tick();
      chk("rr_w0", dout, w0(pk[k % 3]));
      chk("rr_busy0", busy, 1'b1);
      chk("rr_rdy_w0", req_rdy, 3'b000);
      tick();
      chk("rr_w1", dout, w1(pk[k % 3]));
      chk("rr_busy1", busy, 1'b1);
      if (k == 5) req_vld = 3'b000;
    end
    tick();
    chk("rr_idle", dout, 72'h0);
    chk("rr_busy_idle", busy, 1'b0);

    // TX_WAIT raised during W0 of a requester-1 packet
    req_vld = 3'b010;
    #1;
    chk("tw_rdy", req_rdy, 3'b010);
    tick();
    chk("tw_w0", dout, w0(pk[1]));
    tx_wait = 1'b1;
    tick();
    chk("tw_w1", dout, w1(pk[1]));
    chk("tw_rdy_w1", req_rdy, 3'b000);
    tick();
    chk("tw_idle", dout, 72'h0);
    chk("tw_busy_idle", busy, 1'b0);
    chk("tw_rdy_idle", req_rdy, 3'b000);
    tick();
    chk("tw_idle2", dout, 72'h0);
    tx_wait = 1'b0;
    #1;
    chk("tw_rdy_rel", req_rdy, 3'b010);
    tick();
    chk("tw_w0b", dout, w0(pk[1]));
    req_vld = 3'b000;
    tick();
    chk("tw_w1b", dout, w1(pk[1]));
    tick();
    chk("tw_idle3", dout, 72'h0);

    // elink_disable with requester 2 valid
    link_dis = 1'b1;
    req_vld  = 3'b100;
    #1;
    chk("dis_rdy", req_rdy, 3'b000);
    tick();
    chk("dis_dout", dout, 72'h0);
    chk("dis_rdy2", req_rdy, 3'b000);
    tick();
    chk("dis_dout2", dout, 72'h0);
    chk("dis_busy", busy, 1'b0);
    link_dis = 1'b0;
    #1;
    chk("dis_rdy_rel", req_rdy, 3'b100);
    tick();
    chk("dis_w0", dout, w0(pk[2]));
    req_vld = 3'b000;
    tick();
    chk("dis_w1", dout, w1(pk[2]));
    tick();
    chk("dis_idle", dout, 72'h0);

    // Reset pulsed during W0 of a requester-1 packet
    req_vld = 3'b010;
    #1;
    chk("rw_rdy", req_rdy, 3'b010);
    tick();
    chk("rw_w0", dout, w0(pk[1]));
    req_vld = 3'b111;
    rst_n   = 1'b0;
    #1;
    chk("rw_dout_async", dout, 72'h0);
    chk("rw_busy_async", busy, 1'b0);
    chk("rw_rdy_rst", req_rdy, 3'b000);
    req_vld = 3'b000;
    rst_n   = 1'b1;
    tick();
    chk("rw_no_w1", dout, 72'h0);
    chk("rw_busy_rel", busy, 1'b0);
    req_vld = 3'b111;
    #1;
    chk("rw_prio0", req_rdy, 3'b001);
    tick();
    chk("rw_w0_p0", dout, w0(pk[0]));
    req_vld = 3'b000;
    tick();
    chk("rw_w1_p0", dout, w1(pk[0]));
    tick();
    chk("rw_idle", dout, 72'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
